// File: rtl/shift_pkg.sv
// Shared types and default sizes for the shared barrel-rotator arbiter.
package shift_pkg;

  localparam int SHIFT_N = 64;
  localparam int SHIFT_M = 6;

  // Identifies which requester issued an operation.
  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  // Occupancy of the one-entry result slot.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/shift_arbiter_barrel_rotl.sv
// Combinational left-rotator built from M power-of-two stages.
module barrel_rotl
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N,
  parameter int M = SHIFT_M
) (
  input  logic [N-1:0] in_bits,
  input  logic [M-1:0] amt,
  output logic [N-1:0] out_bits
);

  logic [N-1:0] stage [M+1];

  assign stage[0] = in_bits;

  // Stage s rotates left by 2**s when bit s of the amount is set.
  for (genvar s = 0; s < M; s++) begin : g_stage
    localparam int SH = 1 << s;
    assign stage[s+1] = amt[s] ? {stage[s][N-SH-1:0], stage[s][N-1:N-SH]} : stage[s];
  end

  assign out_bits = stage[M];

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel rotator between two requesters,
// with a one-entry tagged result slot and per-requester grant counters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N  = SHIFT_N,
  parameter int M  = SHIFT_M,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [N-1:0]  req0_data,
  input  logic [M-1:0]  req0_amt,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [N-1:0]  req1_data,
  input  logic [M-1:0]  req1_amt,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          out_id,
  output logic [CW-1:0] grant_cnt0,
  output logic [CW-1:0] grant_cnt1
);

  if (N != (1 << M)) begin : g_bad_size
    $error("shift_arbiter: N must equal 2**M");
  end

  slot_state_t state_q;
  slot_state_t state_d;
  req_id_t     last_grant;
  req_id_t     grant_id;
  req_id_t     out_id_q;
  logic        grant_valid;
  logic        slot_free;
  logic        accept;
  logic [N-1:0] rot_in;
  logic [N-1:0] rot_out;
  logic [M-1:0] rot_amt;

  assign out_valid = (state_q == FULL);
  assign out_id    = out_id_q;

  // The slot can take a new result when empty or being drained this cycle.
  assign slot_free = !out_valid || out_ready;

  // Round-robin choice: on contention the requester that did not win last time goes.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ0;
    if (req0_valid && req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = (last_grant == REQ0) ? REQ1 : REQ0;
    end else if (req0_valid) begin
      grant_valid = 1'b1;
      grant_id    = REQ0;
    end else if (req1_valid) begin
      grant_valid = 1'b1;
      grant_id    = REQ1;
    end
  end

  // Ready is withheld while reset is held so nothing is accepted into a clearing slot.
  assign accept     = grant_valid && slot_free && !reset;
  assign req0_ready = accept && (grant_id == REQ0);
  assign req1_ready = accept && (grant_id == REQ1);

  assign rot_in  = (grant_id == REQ1) ? req1_data : req0_data;
  assign rot_amt = (grant_id == REQ1) ? req1_amt  : req0_amt;

  barrel_rotl #(
    .N (N),
    .M (M)
  ) u_rotl (
    .in_bits  (rot_in),
    .amt      (rot_amt),
    .out_bits (rot_out)
  );

  // Slot occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot fills on accept and empties only when drained with nothing new arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Result payload and round-robin history update only on an accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_id_q   <= REQ0;
      last_grant <= REQ1;
    end else if (accept) begin
      out_data   <= rot_out;
      out_id_q   <= grant_id;
      last_grant <= grant_id;
    end
  end

  // Debug counters of accepted operations, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      if (grant_id == REQ0) begin
        grant_cnt0 <= grant_cnt0 + 1'b1;
      end else begin
        grant_cnt1 <= grant_cnt1 + 1'b1;
      end
    end
  end

endmodule
